// File: rtl/lcd_text_buffer.sv
// -----------------------------------------------------------------------------
// lcd_text_buffer
//
// Double-buffered text store feeding a 16x2 character-LCD driver. ASCII bytes
// arrive over a valid/ready stream and land in a 32-character back buffer at
// the cursor. A commit copies the back buffer into the front buffer
// (LINE1/LINE2), so the LCD driver can sample at any time and never shows
// half-written text. Form-feed blanks the back buffer over 32 cycles.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   char_in      byte to write (character or control code)
//   char_valid   char_in is valid
//   char_ready   a byte can be accepted this cycle (high only in IDLE)
//   commit       request to publish the back buffer on LINE1/LINE2
//   LINE1        front buffer line 1, col0 in [127:120], col15 in [7:0]
//   LINE2        front buffer line 2, same packing
//   cursor       next write slot: [4] = line (0 = line 1), [3:0] = column
//   busy         high while the back buffer is being cleared
//   commit_done  one-cycle pulse after LINE1/LINE2 have been updated
// -----------------------------------------------------------------------------
module lcd_text_buffer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter logic [7:0] NL_CODE    = 8'h0A,
  parameter logic [7:0] FF_CODE    = 8'h0C
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic         char_ready,
  input  logic         commit,
  output logic [127:0] LINE1,
  output logic [127:0] LINE2,
  output logic [4:0]   cursor,
  output logic         busy,
  output logic         commit_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] back [32];
  logic [4:0] clr_idx;
  logic       commit_pending;

  logic accept;
  logic publish;
  logic clear_last;
  logic is_nl;
  logic is_ff;

  assign accept     = char_valid && char_ready;
  assign is_nl      = (char_in == NL_CODE);
  assign is_ff      = (char_in == FF_CODE);
  // A commit requested during CLEAR is held and runs on the first IDLE edge.
  assign publish    = (state == IDLE) && (commit || commit_pending);
  assign clear_last = (state == CLEAR) && (clr_idx == 5'd31);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // sees pre-edge values of the others (e.g. the commit copy reads the old
  // back buffer even when a byte is written at the same edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:  if (accept && is_ff) state_next = CLEAR;
      CLEAR: if (clear_last)      state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    char_ready = (state == IDLE);
    busy       = (state == CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Back buffer
  // ---------------------------------------------------------------------------
  // NOTE: the back buffer is reset explicitly because the reset contents are
  // visible (a commit right after reset must publish blanks); this keeps it in
  // flops rather than a RAM macro, which is fine at 32 bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) back[i] <= BLANK_CHAR;
    end else if (state == CLEAR) begin
      back[clr_idx] <= BLANK_CHAR;
    end else if (accept && !is_nl && !is_ff) begin
      back[cursor] <= char_in;
    end
  end

  // Cursor: plain bytes advance mod 32, newline toggles line and homes column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor <= 5'd0;
    end else if (accept) begin
      if (is_nl)      cursor <= {~cursor[4], 4'd0};
      else if (is_ff) cursor <= 5'd0;
      else            cursor <= cursor + 5'd1;
    end
  end

  // Clear index wraps back to 0 on the last CLEAR edge, ready for next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_idx <= 5'd0;
    else if (state == CLEAR)   clr_idx <= clr_idx + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          commit_pending <= 1'b0;
    else if (publish)                    commit_pending <= 1'b0;
    else if (state == CLEAR && commit)   commit_pending <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Front buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LINE1       <= {16{BLANK_CHAR}};
      LINE2       <= {16{BLANK_CHAR}};
      commit_done <= 1'b0;
    end else begin
      commit_done <= publish;
      if (publish) begin
        for (int i = 0; i < 16; i++) begin
          LINE1[127-8*i -: 8] <= back[i];
          LINE2[127-8*i -: 8] <= back[16+i];
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_buffer
//
// Directed bench for lcd_text_buffer. Each commit request pushes the
// hand-computed LINE1/LINE2 image into a scoreboard queue; a monitor pops and
// compares whenever commit_done pulses. Cursor, handshake and reset state are
// compared directly.
// -----------------------------------------------------------------------------
module tb_lcd_text_buffer;

  typedef struct {
    string        name;
    logic [127:0] l1;
    logic [127:0] l2;
  } exp_t;

  localparam logic [127:0] BL = {16{8'h20}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   char_in;
  logic         char_valid;
  logic         char_ready;
  logic         commit;
  logic [127:0] LINE1;
  logic [127:0] LINE2;
  logic [4:0]   cursor;
  logic         busy;
  logic         commit_done;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  lcd_text_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .commit      (commit),
    .LINE1       (LINE1),
    .LINE2       (LINE2),
    .cursor      (cursor),
    .busy        (busy),
    .commit_done (commit_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every commit_done pulse must match the oldest request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && commit_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_commit_done: got pulse want none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_line1"}, LINE1, e.l1);
        check({e.name, "_line2"}, LINE2, e.l2);
      end
    end
  end

  // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (char_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready("send");
    char_in    = b;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic do_commit(input string name, input logic [127:0] l1, input logic [127:0] l2);
    sb_q.push_back('{name, l1, l2});
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cnt_ready;
    int cnt_busy;

    rst_n      = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    commit     = 1'b0;
    #2;

    // 1. Reset state, held for 5 cycles after release.
    do_reset();
    repeat (5) tick();
    @(negedge clk);
    check("rst_line1",       LINE1,       BL);
    check("rst_line2",       LINE2,       BL);
    check("rst_cursor",      cursor,      0);
    check("rst_char_ready",  char_ready,  1);
    check("rst_busy",        busy,        0);
    check("rst_commit_done", commit_done, 0);
    tick();

    // 2. "HI" then commit.
    send(8'h48);
    send(8'h49);
    do_commit("hi", {8'h48, 8'h49, {14{8'h20}}}, BL);
    repeat (2) tick();
    check("hi_cursor", cursor, 5'd2);

    // 3. 17 x 'A' from home: spills one char onto line 2.
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h41);
    check("a17_cursor", cursor, 5'd17);
    do_commit("a17", {16{8'h41}}, {8'h41, {15{8'h20}}});
    tick();

    // 4. Newline from line 2 col 3 returns to line 1 col 0.
    send(8'h42);
    send(8'h43);
    check("l2c3_cursor", cursor, 5'd19);
    send(8'h0A);
    check("nl_l2_cursor", cursor, 5'd0);
    send(8'h5A);
    do_commit("nl", {8'h5A, {15{8'h41}}}, {8'h41, 8'h42, 8'h43, {13{8'h20}}});
    tick();

    // Wrap 31 -> 0, then newline on line 1 goes to line 2 col 0.
    for (int i = 0; i < 30; i++) send(8'h2E);
    check("slot31_cursor", cursor, 5'd31);
    send(8'h51);
    check("wrap_cursor", cursor, 5'd0);
    do_commit("wrap", {8'h5A, {15{8'h2E}}}, {{15{8'h2E}}, 8'h51});
    send(8'h0A);
    check("nl_l1_cursor", cursor, 5'd16);
    send(8'h4B);

    // Commit and FF at the same edge: pre-clear contents are published.
    wait_ready("ffc");
    sb_q.push_back('{"ff_same_edge", {8'h5A, {15{8'h2E}}}, {8'h4B, {14{8'h2E}}, 8'h51}});
    char_in    = 8'h0C;
    char_valid = 1'b1;
    commit     = 1'b1;
    tick();
    char_valid = 1'b0;
    commit     = 1'b0;
    wait_ready("ffc_done");
    check("ffc_cursor", cursor, 5'd0);

    // 5. FF with a commit 3 cycles into CLEAR: 32 not-ready cycles, then
    //    a single blank publish.
    send(8'h58);
    send(8'h0C);
    cnt_ready = 0;
    cnt_busy  = 0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (char_ready === 1'b1) break;
          cnt_ready++;
          if (busy === 1'b1) cnt_busy++;
        end
      end
      begin
        repeat (2) tick();
        do_commit("pending", BL, BL);
      end
    join
    check("clear_not_ready_cycles", cnt_ready, 32);
    check("clear_busy_cycles",      cnt_busy,  32);
    repeat (3) tick();
    check("pending_drained", sb_q.size(), 0);

    // 6. Reset in the middle of CLEAR.
    send(8'h52);
    do_commit("pre_rst", {8'h52, {15{8'h20}}}, BL);
    send(8'h41);
    send(8'h0C);
    repeat (9) tick();
    check("midclear_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_line1",      LINE1,      BL);
    check("async_rst_busy",       busy,       0);
    check("async_rst_char_ready", char_ready, 1);
    check("async_rst_cursor",     cursor,     0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_char_ready", char_ready, 1);
    check("post_rst_busy",       busy,       0);
    tick();
    do_commit("post_rst", BL, BL);
    repeat (3) tick();
    check("final_queue_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
